// File: rtl/lcd_fill_sequencer_pkg.sv
// Shared constants, DCS opcodes and FSM state type for the ST7789 rectangle
// fill sequencer.
//   Package lcd_pkg: panel geometry (240x135 visible, controller offsets 40/53),
//   DCS opcodes, datapath widths, fill_state_t, and a helper that picks one
//   byte of a {start, end} address pair.
package lcd_pkg;

  localparam int unsigned PANEL_W     = 240;
  localparam int unsigned PANEL_H     = 135;
  localparam int unsigned PANEL_X_OFF = 40;
  localparam int unsigned PANEL_Y_OFF = 53;

  localparam int unsigned COORD_W = 8;
  localparam int unsigned COLOR_W = 16;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [BYTE_W-1:0] DCS_SLPOUT = 8'h11;
  localparam logic [BYTE_W-1:0] DCS_CASET  = 8'h2A;
  localparam logic [BYTE_W-1:0] DCS_RASET  = 8'h2B;
  localparam logic [BYTE_W-1:0] DCS_RAMWR  = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET_CMD,
    ST_CASET_DAT,
    ST_RASET_CMD,
    ST_RASET_DAT,
    ST_RAMWR_CMD,
    ST_PIXEL
  } fill_state_t;

  // Byte idx of the 4-byte CASET/RASET payload: start hi, start lo, end hi, end lo.
  function automatic logic [BYTE_W-1:0] addr_byte(input logic [ADDR_W-1:0] s,
                                                  input logic [ADDR_W-1:0] e,
                                                  input logic [1:0]        idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = s[15:8];
      2'd1:    b = s[7:0];
      2'd2:    b = e[15:8];
      default: b = e[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_fill_sequencer_if.sv
// Request and byte-stream bus between drawing logic, the fill sequencer and
// the SPI byte transmitter.
//   req_*  : rectangle request (valid/ready) with inclusive corners and colour
//   tx_*   : byte stream toward the transmitter (valid/ready), dc and last flags
//   master : drawing logic / transmitter side; slave : the fill sequencer
interface lcd_fill_sequencer_if;
  import lcd_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [COORD_W-1:0]   req_x0;
  logic [COORD_W-1:0]   req_x1;
  logic [COORD_W-1:0]   req_y0;
  logic [COORD_W-1:0]   req_y1;
  logic [COLOR_W-1:0]   req_color;

  logic                 tx_valid;
  logic                 tx_ready;
  logic [BYTE_W-1:0]    tx_byte;
  logic                 tx_dc;
  logic                 tx_last;

  modport master (
    output req_valid, req_x0, req_x1, req_y0, req_y1, req_color, tx_ready,
    input  req_ready, tx_valid, tx_byte, tx_dc, tx_last
  );

  modport slave (
    input  req_valid, req_x0, req_x1, req_y0, req_y1, req_color, tx_ready,
    output req_ready, tx_valid, tx_byte, tx_dc, tx_last
  );

endinterface

// File: rtl/lcd_fill_sequencer.sv
// Solid-colour rectangle fill for the ST7789 panel: accepts one request at a
// time and emits CASET, RASET, RAMWR and the RGB565 pixel stream as bytes.
//   clk, resetn : clock, asynchronous active-low reset
//   lcd_ready   : panel init done; gates request acceptance only
//   bus         : request and tx byte-stream handshakes (slave modport)
//   busy        : accepted request in flight
//   done        : one-cycle pulse after the final byte handshake
//   err         : one-cycle pulse on a rejected request
module lcd_fill_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned WIDTH  = PANEL_W,
  parameter int unsigned HEIGHT = PANEL_H,
  parameter int unsigned X_OFF  = PANEL_X_OFF,
  parameter int unsigned Y_OFF  = PANEL_Y_OFF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 lcd_ready,
  lcd_fill_sequencer_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  fill_state_t          state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic                 phase_q, phase_d;
  logic [COORD_W-1:0]   col_q, col_d;
  logic [COORD_W-1:0]   row_q, row_d;
  logic [COORD_W-1:0]   x0_q, x1_q, y0_q, y1_q;
  logic [COLOR_W-1:0]   color_q;

  logic                 tx_valid_q, tx_valid_d;
  logic [BYTE_W-1:0]    tx_byte_q, tx_byte_d;
  logic                 tx_dc_q, tx_dc_d;
  logic                 tx_last_q, tx_last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 req_ready_c;
  logic                 req_fire_c;
  logic                 req_ok_c;
  logic                 tx_fire_c;
  logic                 pix_last_c;
  logic                 pix_last_next_c;
  logic [COORD_W-1:0]   col_span_c;
  logic [COORD_W-1:0]   row_span_c;
  logic [ADDR_W-1:0]    xs_c, xe_c, ys_c, ye_c;

  assign req_ready_c = (state_q == ST_IDLE) && lcd_ready;
  assign req_fire_c  = bus.req_valid && req_ready_c;
  assign req_ok_c    = (bus.req_x0 <= bus.req_x1) && (bus.req_y0 <= bus.req_y1) &&
                       (32'(bus.req_x1) < WIDTH) && (32'(bus.req_y1) < HEIGHT);
  assign tx_fire_c   = tx_valid_q && bus.tx_ready;

  // Counters run 0..span so no pixel-count multiply is needed.
  assign col_span_c      = COORD_W'(x1_q - x0_q);
  assign row_span_c      = COORD_W'(y1_q - y0_q);
  assign pix_last_c      = (col_q == col_span_c) && (row_q == row_span_c);
  assign pix_last_next_c = (col_d == col_span_c) && (row_d == row_span_c);

  assign xs_c = ADDR_W'(x0_q) + ADDR_W'(X_OFF);
  assign xe_c = ADDR_W'(x1_q) + ADDR_W'(X_OFF);
  assign ys_c = ADDR_W'(y0_q) + ADDR_W'(Y_OFF);
  assign ye_c = ADDR_W'(y1_q) + ADDR_W'(Y_OFF);

  // State, counter, request and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      phase_q    <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= '0;
      tx_dc_q    <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      col_q      <= col_d;
      row_q      <= row_d;
      if (req_fire_c) begin
        x0_q    <= bus.req_x0;
        x1_q    <= bus.req_x1;
        y0_q    <= bus.req_y0;
        y1_q    <= bus.req_y1;
        color_q <= bus.req_color;
      end
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      tx_dc_q    <= tx_dc_d;
      tx_last_q  <= tx_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next state: advance one byte position per tx handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire_c && req_ok_c) state_d = ST_CASET_CMD;
      end
      ST_CASET_CMD: begin
        if (tx_fire_c) begin
          state_d = ST_CASET_DAT;
          idx_d   = 2'd0;
        end
      end
      ST_CASET_DAT: begin
        if (tx_fire_c) begin
          if (idx_q == 2'd3) begin
            state_d = ST_RASET_CMD;
            idx_d   = 2'd0;
          end else begin
            idx_d = 2'(idx_q + 2'd1);
          end
        end
      end
      ST_RASET_CMD: begin
        if (tx_fire_c) begin
          state_d = ST_RASET_DAT;
          idx_d   = 2'd0;
        end
      end
      ST_RASET_DAT: begin
        if (tx_fire_c) begin
          if (idx_q == 2'd3) begin
            state_d = ST_RAMWR_CMD;
            idx_d   = 2'd0;
          end else begin
            idx_d = 2'(idx_q + 2'd1);
          end
        end
      end
      ST_RAMWR_CMD: begin
        if (tx_fire_c) begin
          state_d = ST_PIXEL;
          phase_d = 1'b0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_PIXEL: begin
        if (tx_fire_c) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (pix_last_c) begin
            state_d = ST_IDLE;
            phase_d = 1'b0;
          end else begin
            phase_d = 1'b0;
            if (col_q == col_span_c) begin
              col_d = '0;
              row_d = COORD_W'(row_q + COORD_W'(1));
            end else begin
              col_d = COORD_W'(col_q + COORD_W'(1));
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: load the byte for the next position on accept or handshake, else hold.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_byte_d  = tx_byte_q;
    tx_dc_d    = tx_dc_q;
    tx_last_d  = tx_last_q;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_q == ST_PIXEL) && (state_d == ST_IDLE);
    err_d      = req_fire_c && !req_ok_c;
    if (state_d == ST_IDLE) begin
      tx_valid_d = 1'b0;
      tx_last_d  = 1'b0;
    end else if ((state_q == ST_IDLE) || tx_fire_c) begin
      tx_valid_d = 1'b1;
      tx_dc_d    = 1'b1;
      tx_last_d  = 1'b0;
      case (state_d)
        ST_CASET_CMD: begin
          tx_byte_d = DCS_CASET;
          tx_dc_d   = 1'b0;
        end
        ST_CASET_DAT: begin
          tx_byte_d = addr_byte(xs_c, xe_c, idx_d);
          tx_last_d = (idx_d == 2'd3);
        end
        ST_RASET_CMD: begin
          tx_byte_d = DCS_RASET;
          tx_dc_d   = 1'b0;
        end
        ST_RASET_DAT: begin
          tx_byte_d = addr_byte(ys_c, ye_c, idx_d);
          tx_last_d = (idx_d == 2'd3);
        end
        ST_RAMWR_CMD: begin
          tx_byte_d = DCS_RAMWR;
          tx_dc_d   = 1'b0;
        end
        ST_PIXEL: begin
          tx_byte_d = phase_d ? color_q[7:0] : color_q[15:8];
          tx_last_d = phase_d && pix_last_next_c;
        end
        default: begin
          tx_byte_d = '0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_dc     = tx_dc_q;
  assign bus.tx_last   = tx_last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
